infix_to_postfix: RTL and testbench

- Shunting-yard converter that turns the tokenised infix expression into the postfix token array and size consumed by the postfix evaluator.
- Its done pulse drives the evaluator's conv input.
- Sits between the keypad/tokeniser front end and the evaluator.
- Same 44-bit token format as the rest of the calculator datapath.

---
 rtl/calc_pkg.sv | 64 ++++++
 rtl/op_stack.sv | 57 +++++
 rtl/infix_to_postfix.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_infix_to_postfix.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: token fields, operator
// codes, converter state encoding and operator classification helpers.
package calc_pkg;

  // Token ident field values ([43:42])
  localparam logic [1:0] IDENT_NUM = 2'b00;
  localparam logic [1:0] IDENT_OP  = 2'b01;

  // Operator codes ([7:0])
  localparam logic [7:0] OP_ADD   = 8'h2A;
  localparam logic [7:0] OP_SUB   = 8'h2B;
  localparam logic [7:0] OP_MUL   = 8'h2C;
  localparam logic [7:0] OP_DIV   = 8'h2D;
  localparam logic [7:0] OP_EXP   = 8'hF0;
  localparam logic [7:0] OP_LN    = 8'hF1;
  localparam logic [7:0] OP_POW   = 8'hF2;
  localparam logic [7:0] OP_LOG   = 8'hF3;
  localparam logic [7:0] OP_SIN   = 8'hF4;
  localparam logic [7:0] OP_COS   = 8'hF5;
  localparam logic [7:0] OP_TAN   = 8'hF6;
  localparam logic [7:0] OP_LB    = 8'h28;
  localparam logic [7:0] OP_RB    = 8'h29;
  localparam logic [7:0] OP_COMMA = 8'h2E;

  // Unused mantissa bit of an operator token, used on the stack to tag a
  // unary minus; it is cleared again before the token reaches postfix.
  localparam int NEG_BIT = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_PUSH_NEG,
    S_POP_PREC,
    S_POP_RB,
    S_RB_FUNC,
    S_POP_COMMA,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic logic is_binary(input logic [7:0] code);
    return code inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_func(input logic [7:0] code);
    return code inside {OP_EXP, OP_LN, OP_POW, OP_LOG, OP_SIN, OP_COS, OP_TAN};
  endfunction

  function automatic logic is_known(input logic [7:0] code);
    return is_binary(code) || is_func(code) ||
           (code inside {OP_LB, OP_RB, OP_COMMA});
  endfunction

  // Binding strength of a binary operator; a tagged unary minus binds tightest.
  function automatic logic [1:0] prec(input logic [7:0] code, input logic neg);
    logic [1:0] p;
    p = 2'd0;
    if (neg)                                   p = 2'd3;
    else if (code inside {OP_ADD, OP_SUB})     p = 2'd1;
    else if (code inside {OP_MUL, OP_DIV})     p = 2'd2;
    return p;
  endfunction

endpackage

// File: rtl/op_stack.sv
// LIFO operator stack for the shunting-yard converter. Push and pop in the
// same cycle replace the top entry. Also exposes the ident/code of the entry
// below the top so a closing bracket can see a pending function early.
module op_stack #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 44
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [9:0]                 second_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Read side: top entry and the tag of the entry beneath it
  always_comb begin
    top        = '0;
    second_tag = '0;
    if (!empty) top = mem[count - CW'(1)];
    if (count >= CW'(2))
      second_tag = {mem[count - CW'(2)][WIDTH-1 -: 2], mem[count - CW'(2)][7:0]};
  end

  // Storage and occupancy update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: if (!full) begin
          mem[count] <= din;
          count      <= count + CW'(1);
        end
        2'b01: if (!empty) count <= count - CW'(1);
        2'b11: if (!empty) mem[count - CW'(1)] <= din;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/infix_to_postfix.sv
// Shunting-yard converter: turns a tokenised infix expression into the
// postfix token array consumed by the evaluator. done pulses once per
// conversion; error is sticky until the next accepted conv edge.
// Optional build macro INFIX2POST_UNARY_MINUS_EN: treats a leading sub, or a
// sub after LB, comma or a binary op, as unary minus (emits 0, pushes sub
// with the highest precedence).
module infix_to_postfix
  import calc_pkg::*;
#(
  parameter int depth    = 10,
  parameter int newWidth = 44
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       conv,
  input  logic [$clog2(depth+1)-1:0] infixSize,
  input  logic [newWidth-1:0]        infix [depth],
  output logic [newWidth-1:0]        postfix [depth],
  output logic [$clog2(depth+1)-1:0] postfixSize,
  output logic                       done,
  output logic                       error
);

  localparam int SW = $clog2(depth+1);

  state_t state, next_state;

  logic                conv_q;
  logic                conv_edge;
  logic [SW-1:0]       index;
  logic [SW-1:0]       size_eff;
  logic [newWidth-1:0] cur_tok;
  logic [1:0]          cur_ident;
  logic [7:0]          cur_code;
  logic                room;

  logic                st_push, st_pop, st_clear;
  logic [newWidth-1:0] st_din, st_top;
  logic [9:0]          st_second;
  logic [SW-1:0]       st_count;
  logic                st_full, st_empty;
  logic                top_is_op, top_is_bin, top_is_lb, second_is_func;

  logic                start, app_en, idx_inc, set_err;
  logic [newWidth-1:0] app_tok, neg_tok, top_plain;

  op_stack #(.DEPTH(depth), .WIDTH(newWidth)) u_stack (
    .clock      (clock),
    .reset      (reset),
    .clear      (st_clear),
    .push       (st_push),
    .pop        (st_pop),
    .din        (st_din),
    .top        (st_top),
    .second_tag (st_second),
    .count      (st_count),
    .full       (st_full),
    .empty      (st_empty)
  );

  assign conv_edge = conv & ~conv_q;
  assign size_eff  = (infixSize > SW'(depth)) ? SW'(depth) : infixSize;
  assign cur_tok   = infix[index];
  assign cur_ident = cur_tok[newWidth-1 -: 2];
  assign cur_code  = cur_tok[7:0];
  assign room      = (postfixSize < SW'(depth));
  assign done      = (state == S_DONE);

  assign top_is_op      = !st_empty && (st_top[newWidth-1 -: 2] == IDENT_OP);
  assign top_is_bin     = top_is_op && is_binary(st_top[7:0]);
  assign top_is_lb      = top_is_op && (st_top[7:0] == OP_LB);
  assign second_is_func = (st_second[9:8] == IDENT_OP) && is_func(st_second[7:0]);

  // Token variants: incoming sub tagged as unary, stack top with tag removed
  always_comb begin
    neg_tok            = cur_tok;
    neg_tok[NEG_BIT]   = 1'b1;
    top_plain          = st_top;
    top_plain[NEG_BIT] = 1'b0;
  end

`ifdef INFIX2POST_UNARY_MINUS_EN
  logic          is_unary;
  logic [SW-1:0] prev_idx;

  // A sub is unary at the start or right after LB, comma or a binary op
  always_comb begin
    prev_idx = index - SW'(1);
    is_unary = 1'b0;
    if (cur_code == OP_SUB) begin
      if (index == '0)
        is_unary = 1'b1;
      else if (infix[prev_idx][newWidth-1 -: 2] == IDENT_OP &&
               ((infix[prev_idx][7:0] inside {OP_LB, OP_COMMA}) ||
                is_binary(infix[prev_idx][7:0])))
        is_unary = 1'b1;
    end
  end
`endif

  // State register and conv edge history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      conv_q <= 1'b0;
    end else begin
      state  <= next_state;
      conv_q <= conv;
    end
  end

  // Next-state and datapath control strobes
  always_comb begin
    next_state = state;
    st_push    = 1'b0;
    st_pop     = 1'b0;
    st_clear   = 1'b0;
    st_din     = cur_tok;
    start      = 1'b0;
    app_en     = 1'b0;
    app_tok    = top_plain;
    idx_inc    = 1'b0;
    set_err    = 1'b0;

    unique case (state)
      S_IDLE: if (conv_edge) begin
        start      = 1'b1;
        st_clear   = 1'b1;
        next_state = S_READ;
      end

      S_READ: begin
        if (index >= size_eff) begin
          next_state = S_FLUSH;
        end else if (cur_ident == IDENT_NUM) begin
          if (room) begin
            app_en  = 1'b1;
            app_tok = cur_tok;
            idx_inc = 1'b1;
          end else begin
            set_err = 1'b1; next_state = S_DONE;
          end
        end else if (cur_ident != IDENT_OP || !is_known(cur_code)) begin
          set_err = 1'b1; next_state = S_DONE;
        end else if (is_func(cur_code) || cur_code == OP_LB) begin
          if (st_full) begin
            set_err = 1'b1; next_state = S_DONE;
          end else begin
            st_push = 1'b1;
            idx_inc = 1'b1;
          end
        end else if (cur_code == OP_RB) begin
          next_state = S_POP_RB;
        end else if (cur_code == OP_COMMA) begin
          next_state = S_POP_COMMA;
        end else begin
`ifdef INFIX2POST_UNARY_MINUS_EN
          if (is_unary) begin
            if (room) begin
              app_en     = 1'b1;
              app_tok    = '0;
              next_state = S_PUSH_NEG;
            end else begin
              set_err = 1'b1; next_state = S_DONE;
            end
          end else begin
            next_state = S_POP_PREC;
          end
`else
          next_state = S_POP_PREC;
`endif
        end
      end

      S_PUSH_NEG: begin
        if (st_full) begin
          set_err = 1'b1; next_state = S_DONE;
        end else begin
          st_push    = 1'b1;
          st_din     = neg_tok;
          idx_inc    = 1'b1;
          next_state = S_READ;
        end
      end

      S_POP_PREC: begin
        if (top_is_bin && prec(st_top[7:0], st_top[NEG_BIT]) >= prec(cur_code, 1'b0)) begin
          if (room) begin
            st_pop = 1'b1; app_en = 1'b1;
          end else begin
            set_err = 1'b1; next_state = S_DONE;
          end
        end else if (st_full) begin
          set_err = 1'b1; next_state = S_DONE;
        end else begin
          st_push    = 1'b1;
          idx_inc    = 1'b1;
          next_state = S_READ;
        end
      end

      S_POP_RB: begin
        if (st_empty) begin
          set_err = 1'b1; next_state = S_DONE;
        end else if (top_is_lb) begin
          st_pop = 1'b1;
          if (second_is_func) begin
            next_state = S_RB_FUNC;
          end else begin
            idx_inc    = 1'b1;
            next_state = S_READ;
          end
        end else if (room) begin
          st_pop = 1'b1; app_en = 1'b1;
        end else begin
          set_err = 1'b1; next_state = S_DONE;
        end
      end

      S_RB_FUNC: begin
        if (room) begin
          st_pop     = 1'b1;
          app_en     = 1'b1;
          idx_inc    = 1'b1;
          next_state = S_READ;
        end else begin
          set_err = 1'b1; next_state = S_DONE;
        end
      end

      S_POP_COMMA: begin
        if (st_empty) begin
          set_err = 1'b1; next_state = S_DONE;
        end else if (top_is_lb) begin
          idx_inc    = 1'b1;
          next_state = S_READ;
        end else if (room) begin
          st_pop = 1'b1; app_en = 1'b1;
        end else begin
          set_err = 1'b1; next_state = S_DONE;
        end
      end

      S_FLUSH: begin
        if (st_empty) begin
          next_state = S_DONE;
        end else if (top_is_lb || !room) begin
          set_err = 1'b1; next_state = S_DONE;
        end else begin
          st_pop = 1'b1; app_en = 1'b1;
        end
      end

      S_DONE: next_state = S_IDLE;

      default: next_state = S_IDLE;
    endcase
  end

  // Postfix array, read index and sticky error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      postfixSize <= '0;
      index       <= '0;
      error       <= 1'b0;
      for (int i = 0; i < depth; i++) postfix[i] <= '0;
    end else begin
      if (start) begin
        postfixSize <= '0;
        index       <= '0;
        error       <= 1'b0;
      end
      if (app_en) begin
        postfix[postfixSize] <= app_tok;
        postfixSize          <= postfixSize + SW'(1);
      end
      if (idx_inc) index <= index + SW'(1);
      if (set_err) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_infix_to_postfix.sv
// Self-checking bench for infix_to_postfix: table of expressions with
// hand-derived postfix results, a scoreboard queue of expectations, plus
// hand-written sequences for reset mid-conversion, held conv and empty input.
module tb_infix_to_postfix;
  import calc_pkg::*;

  localparam int DEPTH = 10;
  localparam int W     = 44;
  localparam int SW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          conv;
  logic [SW-1:0] infixSize;
  logic [W-1:0]  infix [DEPTH];
  logic [W-1:0]  postfix [DEPTH];
  logic [SW-1:0] postfixSize;
  logic          done;
  logic          error;

  always #5 clock = ~clock;

  infix_to_postfix #(.depth(DEPTH), .newWidth(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .conv        (conv),
    .infixSize   (infixSize),
    .infix       (infix),
    .postfix     (postfix),
    .postfixSize (postfixSize),
    .done        (done),
    .error       (error)
  );

  typedef logic [W-1:0] tok_arr_t [DEPTH];
  typedef struct {
    string    name;
    int       in_n;
    tok_arr_t in_tok;
    int       exp_n;
    tok_arr_t exp_tok;
    logic     exp_err;
  } vec_t;

  vec_t     vecs[$];
  vec_t     sb_q[$];
  tok_arr_t ti, te;
  int       total  = 0;
  int       passed = 0;

  function automatic logic [W-1:0] num(input int v);
    return {2'b00, 1'b0, 34'(v), 7'd0};
  endfunction

  function automatic logic [W-1:0] op(input logic [7:0] c);
    return {2'b01, 34'd0, c};
  endfunction

  task automatic check_output(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic add_vec(input string nm, input int n, input int en, input logic er);
    vec_t v;
    v.name = nm; v.in_n = n; v.in_tok = ti;
    v.exp_n = en; v.exp_tok = te; v.exp_err = er;
    vecs.push_back(v);
  endtask

  // Drive one conversion, wait (bounded) for done, compare with the scoreboard
  task automatic apply_stimulus(input vec_t v, input logic hold, output int lat);
    vec_t e;
    int   cyc;
    logic got;
    @(negedge clock);
    infixSize = SW'(v.in_n);
    infix     = v.in_tok;
    conv      = 1'b1;
    sb_q.push_back(v);
    cyc = 0; got = 1'b0; lat = -1;
    while (cyc < 100 && !got) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (!hold) conv = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = cyc - 1;
        e = sb_q.pop_front();
        check_output({e.name, "_error"}, W'(error), W'(e.exp_err));
        check_output({e.name, "_size"}, W'(postfixSize), W'(e.exp_n));
        for (int i = 0; i < e.exp_n; i++)
          check_output($sformatf("%s_tok%0d", e.name, i), postfix[i], e.exp_tok[i]);
        check_output({e.name, "_latency_ok"}, W'(lat <= 2 * e.in_n + 3), W'(1));
      end
    end
    check_output({v.name, "_done_seen"}, W'(got), W'(1));
    @(negedge clock);
    check_output({v.name, "_done_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   dcount;
    logic any_nz;
    vec_t v;

    ti = '{default: '0}; te = '{default: '0};
    ti = '{0:num(3), 1:op(OP_ADD), 2:num(4), 3:op(OP_MUL), 4:num(2), default:'0};
    te = '{0:num(3), 1:num(4), 2:num(2), 3:op(OP_MUL), 4:op(OP_ADD), default:'0};
    add_vec("prec", 5, 5, 1'b0);
    ti = '{0:op(OP_LB), 1:num(3), 2:op(OP_ADD), 3:num(4), 4:op(OP_RB), 5:op(OP_MUL), 6:num(2), default:'0};
    te = '{0:num(3), 1:num(4), 2:op(OP_ADD), 3:num(2), 4:op(OP_MUL), default:'0};
    add_vec("bracket", 7, 5, 1'b0);
    ti = '{0:op(OP_POW), 1:op(OP_LB), 2:num(2), 3:op(OP_COMMA), 4:num(3), 5:op(OP_RB), default:'0};
    te = '{0:num(2), 1:num(3), 2:op(OP_POW), default:'0};
    add_vec("pow_comma", 6, 3, 1'b0);
    ti = '{0:op(OP_SIN), 1:op(OP_LB), 2:num(1), 3:op(OP_RB), default:'0};
    te = '{0:num(1), 1:op(OP_SIN), default:'0};
    add_vec("sin", 4, 2, 1'b0);
    ti = '{0:num(5), 1:op(OP_SUB), 2:num(2), 3:op(OP_SUB), 4:num(1), default:'0};
    te = '{0:num(5), 1:num(2), 2:op(OP_SUB), 3:num(1), 4:op(OP_SUB), default:'0};
    add_vec("left_assoc", 5, 5, 1'b0);
    ti = '{0:num(3), 1:op(OP_RB), default:'0};
    te = '{0:num(3), default:'0};
    add_vec("rb_no_lb", 2, 1, 1'b1);
    ti = '{0:op(OP_LB), 1:num(3), default:'0};
    te = '{0:num(3), default:'0};
    add_vec("lb_unclosed", 2, 1, 1'b1);
    ti = '{0:num(1), 1:op(8'h55), default:'0};
    te = '{0:num(1), default:'0};
    add_vec("unknown_op", 2, 1, 1'b1);
    ti = '{0:num(1), 1:op(OP_COMMA), default:'0};
    te = '{0:num(1), default:'0};
    add_vec("comma_empty", 2, 1, 1'b1);
    ti = '{0:op(OP_COS), 1:op(OP_LB), 2:num(1), 3:op(OP_RB), 4:op(OP_ADD),
           5:num(2), 6:op(OP_MUL), 7:num(3), 8:op(OP_SUB), 9:num(4)};
    te = '{0:num(1), 1:op(OP_COS), 2:num(2), 3:num(3), 4:op(OP_MUL),
           5:op(OP_ADD), 6:num(4), 7:op(OP_SUB), default:'0};
    add_vec("full_size", 10, 8, 1'b0);
    ti = '{0:op(OP_SUB), 1:num(5), 2:op(OP_MUL), 3:num(2), default:'0};
`ifdef INFIX2POST_UNARY_MINUS_EN
    te = '{0:'0, 1:num(5), 2:op(OP_SUB), 3:num(2), 4:op(OP_MUL), default:'0};
    add_vec("lead_sub", 4, 5, 1'b0);
`else
    te = '{0:num(5), 1:num(2), 2:op(OP_MUL), 3:op(OP_SUB), default:'0};
    add_vec("lead_sub", 4, 4, 1'b0);
`endif

    reset = 1'b1; conv = 1'b0; infixSize = '0;
    infix = '{default: '0};
    repeat (2) @(negedge clock);
    any_nz = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (postfix[i] !== '0) any_nz = 1'b1;
    check_output("reset_postfix_zero", W'(any_nz), W'(0));
    check_output("reset_size", W'(postfixSize), W'(0));
    check_output("reset_done", W'(done), W'(0));
    check_output("reset_error", W'(error), W'(0));
    reset = 1'b0;
    repeat (2) @(negedge clock);

    foreach (vecs[k]) apply_stimulus(vecs[k], 1'b0, lat);

    // Empty input: done exactly two cycles after the accepted edge
    v.name = "empty"; v.in_n = 0; v.in_tok = '{default: '0};
    v.exp_n = 0; v.exp_tok = '{default: '0}; v.exp_err = 1'b0;
    apply_stimulus(v, 1'b0, lat);
    check_output("empty_latency", W'(lat), W'(2));

    // Reset in the middle of a conversion aborts without a done pulse
    @(negedge clock);
    infixSize = SW'(vecs[0].in_n);
    infix     = vecs[0].in_tok;
    conv      = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    conv  = 1'b0;
    #1;
    check_output("midreset_size", W'(postfixSize), W'(0));
    check_output("midreset_done", W'(done), W'(0));
    @(negedge clock);
    reset = 1'b0;
    dcount = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check_output("midreset_no_done", W'(dcount), W'(0));
    apply_stimulus(vecs[0], 1'b0, lat);

    // conv held high: one conversion only, result stays put afterwards
    apply_stimulus(vecs[1], 1'b1, lat);
    dcount = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check_output("held_conv_single_done", W'(dcount), W'(0));
    check_output("held_conv_size_stable", W'(postfixSize), W'(vecs[1].exp_n));
    check_output("held_conv_tok_stable", postfix[4], vecs[1].exp_tok[4]);
    conv = 1'b0;
    repeat (2) @(negedge clock);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
